// File: rtl/inv_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module   : inv_sub_bytes_seq
// Brief    : Byte-serial AES InvSubBytes engine for a 128-bit state.
//            Each byte is passed through the inverse affine transform and then
//            inverted in GF(2^8) as x^254. The power is computed by
//            square-and-multiply on one shared combinational multiplier.
//            The bytes are processed one after another. No lookup table is used.
// Revision : 1.0 - initial release
// ============================================================================
module inv_sub_bytes_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  // Controller states
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_PREP = 2'd1;
  localparam logic [1:0] c_CALC = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // Exponent of the field inversion (x^254 == x^-1, with 0 -> 0).
  // The exponent is scanned MSB first, one bit per odd step.
  localparam logic [7:0] c_EXP       = 8'hFE;
  localparam logic [3:0] c_LAST_STEP = 4'd15;
  localparam logic [3:0] c_LAST_BYTE = 4'd15;

  logic [1:0]   r_state;
  logic [127:0] r_work;     // input bytes, overwritten in place by results
  logic [3:0]   r_idx;      // byte being processed, 0 = bits [127:120]
  logic [3:0]   r_step;     // square-and-multiply step, 0..15
  logic [7:0]   r_a;        // inverse-affine image of the current byte
  logic [7:0]   r_r;        // running power a^e
  logic [127:0] r_out;      // last completed result

  logic [7:0]   w_cur_byte;
  logic [7:0]   w_affine;
  logic [7:0]   w_mul_b;
  logic [7:0]   w_mul_p;
  logic [127:0] w_work_upd;
  logic         w_last_step;
  logic         w_last_byte;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1. Shift-and-add with xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return acc;
  endfunction

  // Pick the byte addressed by r_idx, using FIPS-197 byte order
  always_comb begin
    w_cur_byte = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (r_idx == 4'(k)) w_cur_byte = r_work[127-8*k -: 8];
    end
  end

  // Inverse affine transform: rotl1 ^ rotl3 ^ rotl6 ^ 0x05
  assign w_affine = {w_cur_byte[6:0], w_cur_byte[7]}
                  ^ {w_cur_byte[4:0], w_cur_byte[7:5]}
                  ^ {w_cur_byte[1:0], w_cur_byte[7:2]}
                  ^ 8'h05;

  // Second multiplier operand. Even steps square r. Odd steps multiply r by a
  // or by 1, depending on the exponent bit. The multiplier is used on every
  // step, so each byte always takes the same number of cycles.
  always_comb begin
    w_mul_b = 8'h01;
    if (!r_step[0]) begin
      w_mul_b = r_r;
    end else if (c_EXP[3'd7 - r_step[3:1]]) begin
      w_mul_b = r_a;
    end
  end

  assign w_mul_p     = gf_mul(r_r, w_mul_b);
  assign w_last_step = (r_step == c_LAST_STEP);
  assign w_last_byte = (r_idx == c_LAST_BYTE);

  // Work register with the finished byte merged in at position r_idx
  always_comb begin
    w_work_upd = r_work;
    for (int k = 0; k < 16; k++) begin
      if (r_idx == 4'(k)) w_work_upd[127-8*k -: 8] = w_mul_p;
    end
  end

  // Controller and datapath: one job in flight; the result is published on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_work  <= '0;
      r_idx   <= 4'd0;
      r_step  <= 4'd0;
      r_a     <= 8'h00;
      r_r     <= 8'h00;
      r_out   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_work  <= in_state;
            r_idx   <= 4'd0;
            r_state <= c_PREP;
          end
        end
        c_PREP: begin
          r_a     <= w_affine;
          r_r     <= 8'h01;
          r_step  <= 4'd0;
          r_state <= c_CALC;
        end
        c_CALC: begin
          r_r    <= w_mul_p;
          r_step <= r_step + 4'd1;
          if (w_last_step) begin
            r_work <= w_work_upd;
            if (w_last_byte) begin
              r_out   <= w_work_upd;
              r_state <= c_DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= c_PREP;
            end
          end
        end
        c_DONE: begin
          if (out_ready) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign busy      = (r_state == c_PREP) || (r_state == c_CALC);
  assign out_state = r_out;

endmodule
`default_nettype wire

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Area-lean InvSubBytes engine for the decrypt direction of the AES-128 datapath. It is the inverse of the existing combinational forward S-box byte mapper. It accepts one 128-bit state over a valid/ready handshake and applies the AES inverse S-box to all 16 bytes, one byte at a time. No 256-entry table is used: each byte goes through the inverse affine transform, then a GF(2^8) inversion computed as x^254 by square-and-multiply on a single shared multiplier.

Parameters:
None. Width is fixed at 128-bit state, 8-bit bytes and the GF(2^8) polynomial 0x11B.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input state offered
in_ready  out  1  block can accept; high only in IDLE
in_state  in  128  ciphertext-side state; byte k = bits [127-8k -: 8], FIPS-197 order
out_valid  out  1  result held and offered
out_ready  in  1  downstream accepts result
out_state  out  128  InvSubBytes(in_state), same byte order
busy  out  1  high in PREP or CALC

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset: state=IDLE; in_ready=1, out_valid=0, busy=0, out_state=0; byte index=0; internal regs cleared.
- Reset mid-operation aborts the current job. The result is discarded and is never presented.
- FSM states: IDLE, PREP, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_state into the work register, idx=0, go to PREP.
- PREP (1 cycle):
  - a = inv_affine(byte[idx]), where inv_affine(b) = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 8'h05.
  - r = 8'h01; step=0; go to CALC.
- CALC (16 cycles, step 0..15), exponent 254 = 8'b11111110 processed MSB first:
  - Even step 2j: r = r*r (GF multiply).
  - Odd step 2j+1: r = r*a if exponent bit (7-j) is 1, else r = r*1. The multiplier is always used.
  - After step 15: write r into byte[idx] of the result register.
  - If idx==15, go to DONE. Otherwise idx++ and go to PREP.
- Zero handling: a==0 gives r=0 naturally (0^254=0), so inv_sbox(0x63)=0x00. No special case is required.
- GF multiply: combinational shift-and-add with xtime reduction by 0x11B; 8-bit in, 8-bit out.
- Latency:
  - 17 cycles per byte, 272 cycles per state.
  - out_valid rises exactly 272 cycles after the input handshake edge, i.e. on the edge entering DONE.
- DONE:
  - out_valid=1; out_state is stable and held while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - in_ready returns high on the following cycle. There is no input/output overlap; single job in flight.
- in_valid during PREP, CALC or DONE is ignored (in_ready=0). in_state changes after the handshake have no effect.
- out_state is updated only on DONE entry. It keeps its last value after the handshake until the next job completes.
- The work register is not visible on outputs during computation.

Test Plan:
- Reset then in_state=128'h63636363_63636363_63636363_63636363 -> out_valid exactly 272 cycles after handshake; out_state=128'h0.
- in_state=128'h7C00ED16_00000000_00000000_00000000 -> out_state=128'h01525 3FF_52525252_52525252_52525252 (bytes 0x01,0x52,0x53,0xFF, then twelve 0x52; no space in the hex).
- Round-trip: feed forward sub_bytes output of random 128-bit states (≥1000 vectors) -> out_state equals the original state; compared against a reference inverse-S-box table for all 256 byte values.
- Backpressure: hold out_ready=0 for 50 cycles after DONE -> out_valid stays 1, out_state stable, in_ready=0, and a second in_valid is not accepted. Release -> one handshake, then in_ready=1 on the next cycle.
- Assert rst at cycle 100 of a job -> next cycle in_ready=1, busy=0, out_valid=0. A new job then completes correctly with no leftover data from the aborted job.
- Back-to-back: in_valid held high and out_ready held high -> each job takes 272 cycles to out_valid plus the handshake cycles, with in_ready high only in IDLE. No job is lost or duplicated over 10 jobs.
